// File: rtl/uvmt_axil_st_slv_ram.sv
`default_nettype none
// ============================================================================
//  Module   : uvmt_axil_st_slv_ram
//  Purpose  : AXI4-Lite slave memory model. It terminates the slave side of
//             the AXI-Lite self-test wrapper. Data is held in a word-addressed
//             RAM with byte strobes, and the model returns OKAY or SLVERR.
//  Ports    : clk, reset_n (async, active-low)
//             AW: awaddr, awvalid, awready
//             W : wdata, wstrb, wvalid, wready
//             B : bresp, bvalid, bready
//             AR: araddr, arvalid, arready
//             R : rdata, rresp, rvalid, rready
//  Options  : UVMT_AXIL_ST_SLV_RAM_ERR_EN - when defined, a word index
//             >= DEPTH returns SLVERR. An erroring write leaves the RAM
//             unchanged, and an erroring read returns 0. When undefined,
//             the index wraps modulo DEPTH and every response is OKAY.
//  Revision : 1.0 - initial release
// ============================================================================
module uvmt_axil_st_slv_ram #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,   // 32 or 64
   parameter int DEPTH      = 256   // power of two
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [ADDR_WIDTH-1:0]     awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   input  logic [ADDR_WIDTH-1:0]     araddr,
   input  logic                      arvalid,
   output logic                      arready,
   output logic [DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                rresp,
   output logic                      rvalid,
   input  logic                      rready
);

   localparam int         STRB_WIDTH  = DATA_WIDTH / 8;
   localparam int         OFFS        = $clog2(STRB_WIDTH);
   localparam int         IDX_WIDTH   = $clog2(DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

   w_state_e                  w_state_q, w_state_d;
   r_state_e                  r_state_q, r_state_d;
   logic                      aw_held_q, aw_held_d;
   logic                      w_held_q, w_held_d;
   logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
   logic                      awready_q, awready_d;
   logic                      wready_q, wready_d;
   logic                      arready_q, arready_d;
   logic                      bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic                      rvalid_q, rvalid_d;
   logic [1:0]                rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

   // A held side comes from its register. Otherwise it comes straight from
   // the bus, so a same-cycle pair of handshakes commits on this edge.
   logic [ADDR_WIDTH-1:0]     aw_addr_eff;
   logic [DATA_WIDTH-1:0]     wdata_eff;
   logic [STRB_WIDTH-1:0]     wstrb_eff;
   logic                      aw_hs, w_hs, ar_hs;
   logic                      aw_err, ar_err;
   logic [IDX_WIDTH-1:0]      aw_idx, ar_idx;
   logic                      wr_en;

   assign aw_addr_eff = aw_held_q ? awaddr_q : awaddr;
   assign wdata_eff   = w_held_q  ? wdata_q  : wdata;
   assign wstrb_eff   = w_held_q  ? wstrb_q  : wstrb;
   assign aw_hs       = awvalid & awready_q;
   assign w_hs        = wvalid  & wready_q;
   assign ar_hs       = arvalid & arready_q;
   assign aw_idx      = aw_addr_eff[OFFS +: IDX_WIDTH];
   assign ar_idx      = araddr[OFFS +: IDX_WIDTH];

`ifdef UVMT_AXIL_ST_SLV_RAM_ERR_EN
   // Any set bit above the RAM index means the word index is >= DEPTH.
   assign aw_err = |aw_addr_eff[ADDR_WIDTH-1:OFFS+IDX_WIDTH];
   assign ar_err = |araddr[ADDR_WIDTH-1:OFFS+IDX_WIDTH];
`else
   assign aw_err = 1'b0;
   assign ar_err = 1'b0;
`endif

   // The byte-offset bits (and the high bits when errors are disabled)
   // are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{aw_addr_eff, araddr};

   // Write channel
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      wr_en     = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = awaddr;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = wdata;
               wstrb_d  = wstrb;
            end
            if (aw_held_d && w_held_d) begin
               wr_en     = ~aw_err;
               bresp_d   = aw_err ? RESP_SLVERR : RESP_OKAY;
               bvalid_d  = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      // Readies are registered. They look ahead to the next state.
      awready_d = (w_state_d == W_IDLE) && !aw_held_d;
      wready_d  = (w_state_d == W_IDLE) && !w_held_d;
   end

   // Read channel. It samples mem_q before this edge's write, which gives
   // read-before-write ordering.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rdata_d   = ar_err ? '0 : mem_q[ar_idx];
               rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
               rvalid_d  = 1'b1;
               r_state_d = R_RESP;
            end
         end
         R_RESP: begin
            if (rready) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         if (wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
               if (wstrb_eff[b]) mem_q[aw_idx][b*8 +: 8] <= wdata_eff[b*8 +: 8];
            end
         end
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign arready = arready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_axil_st_slv_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uvmt_axil_st_slv_ram
//  Purpose  : Self-checking bench for uvmt_axil_st_slv_ram with a 32-bit bus,
//             DEPTH=256. It uses a directed vector table, hand sequences for
//             the multi-cycle corners, and random traffic checked against an
//             array model of the memory.
//  Options  : UVMT_AXIL_ST_SLV_RAM_ERR_EN selects the out-of-range rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uvmt_axil_st_slv_ram;

`ifdef UVMT_AXIL_ST_SLV_RAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] model_mem [256];

   uvmt_axil_st_slv_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256)) dut (
      .clk(clk), .reset_n(reset_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
      int cyc;
      bit aw_done, w_done, hs_aw, hs_w;
      cyc = 0; aw_done = 0; w_done = 0;
      awaddr = a; wdata = d; wstrb = s;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         hs_aw   = awvalid && awready;
         hs_w    = wvalid && wready;
         @(posedge clk); #1;
         cyc++;
         if (hs_aw) aw_done = 1;
         if (hs_w)  w_done  = 1;
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) begin
         check("wr_handshake_timeout", 32'd0, 32'd1);
         resp = 2'b11;
         return;
      end
      check("wr_bvalid_latency", {31'd0, bvalid}, 32'd1);
      resp = bresp;
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      check("wr_bvalid_drop", {31'd0, bvalid}, 32'd0);
      check("wr_awready_back", {31'd0, awready}, 32'd1);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
      int cyc;
      bit done, hs;
      cyc = 0; done = 0;
      araddr = a;
      while (!done && cyc < 40) begin
         arvalid = 1;
         hs = arvalid && arready;
         @(posedge clk); #1;
         cyc++;
         if (hs) done = 1;
      end
      arvalid = 0;
      if (!done) begin
         check("rd_handshake_timeout", 32'd0, 32'd1);
         data = 32'hx; resp = 2'b11;
         return;
      end
      check("rd_rvalid_latency", {31'd0, rvalid}, 32'd1);
      data = rdata; resp = rresp;
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
      check("rd_rvalid_drop", {31'd0, rvalid}, 32'd0);
      check("rd_arready_back", {31'd0, arready}, 32'd1);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] rd, bp_rdata;
      logic [1:0]  rsp, bp_bresp, bp_rresp;

      tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 2'b00};
      tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};
      tbl[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0, 2'b00};
      tbl[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0, 2'b00};
      tbl[4]  = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 2'b00};
      tbl[5]  = '{1'b1, 32'h24,  32'hCAFEF00D, 4'h0, 32'h0, 2'b00};
      tbl[6]  = '{1'b0, 32'h24,  32'h0,        4'h0, 32'h0, 2'b00};
      tbl[7]  = '{1'b1, 32'h0,   32'h12345678, 4'hF, 32'h0, 2'b00};
      tbl[8]  = '{1'b0, 32'h400, 32'h0,        4'h0,
                  ERR_EN ? 32'h0 : 32'h12345678, ERR_EN ? 2'b10 : 2'b00};
      tbl[9]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, ERR_EN ? 2'b10 : 2'b00};
      tbl[10] = '{1'b0, 32'h0,   32'h0,        4'h0,
                  ERR_EN ? 32'h12345678 : 32'hFFFFFFFF, 2'b00};
      tbl[11] = '{1'b0, 32'h13,  32'h0,        4'h0, 32'hDEADBEEF, 2'b00};

      reset_n = 0;
      awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
      araddr = 0; arvalid = 0; rready = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", {31'd0, awready}, 32'd0);
      check("rst_wready",  {31'd0, wready},  32'd0);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_bvalid",  {31'd0, bvalid},  32'd0);
      check("rst_rvalid",  {31'd0, rvalid},  32'd0);
      check("rst_bresp",   {30'd0, bresp},   32'd0);
      check("rst_rresp",   {30'd0, rresp},   32'd0);
      check("rst_rdata",   rdata,            32'd0);
      reset_n = 1;
      @(posedge clk); #1;
      check("post_rst_awready", {31'd0, awready}, 32'd1);
      check("post_rst_wready",  {31'd0, wready},  32'd1);
      check("post_rst_arready", {31'd0, arready}, 32'd1);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, rsp);
            check($sformatf("tbl%0d_bresp", i), {30'd0, rsp}, {30'd0, tbl[i].exp_resp});
         end else begin
            do_read(tbl[i].addr, rd, rsp);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_data);
            check($sformatf("tbl%0d_rresp", i), {30'd0, rsp}, {30'd0, tbl[i].exp_resp});
         end
      end

      // W handshake three cycles ahead of AW
      wdata = 32'h0A0B0C0D; wstrb = 4'hF; wvalid = 1;
      check("dec_wready_pre", {31'd0, wready}, 32'd1);
      @(posedge clk); #1;
      wvalid = 0;
      check("dec_wready_held", {31'd0, wready}, 32'd0);
      check("dec_bvalid_0", {31'd0, bvalid}, 32'd0);
      @(posedge clk); #1;
      check("dec_bvalid_1", {31'd0, bvalid}, 32'd0);
      @(posedge clk); #1;
      check("dec_bvalid_2", {31'd0, bvalid}, 32'd0);
      check("dec_awready", {31'd0, awready}, 32'd1);
      awaddr = 32'h40; awvalid = 1;
      @(posedge clk); #1;
      awvalid = 0;
      check("dec_bvalid_after_aw", {31'd0, bvalid}, 32'd1);
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
      do_read(32'h40, rd, rsp);
      check("dec_readback", rd, 32'h0A0B0C0D);

      // Backpressure on both response channels
      awaddr = 32'h30; wdata = 32'h0BADF00D; wstrb = 4'hF; araddr = 32'h10;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("bp_bvalid", {31'd0, bvalid}, 32'd1);
      check("bp_rvalid", {31'd0, rvalid}, 32'd1);
      check("bp_rdata", rdata, 32'hDEADBEEF);
      bp_bresp = bresp; bp_rresp = rresp; bp_rdata = rdata;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("bp_bvalid_hold", {31'd0, bvalid}, 32'd1);
         check("bp_rvalid_hold", {31'd0, rvalid}, 32'd1);
         check("bp_bresp_hold", {30'd0, bresp}, {30'd0, bp_bresp});
         check("bp_rresp_hold", {30'd0, rresp}, {30'd0, bp_rresp});
         check("bp_rdata_hold", rdata, bp_rdata);
         check("bp_readies_low", {29'd0, awready, wready, arready}, 32'd0);
      end
      bready = 1; rready = 1;
      @(posedge clk); #1;
      bready = 0; rready = 0;
      check("bp_valids_drop", {30'd0, bvalid, rvalid}, 32'd0);
      check("bp_readies_back", {29'd0, awready, wready, arready}, 32'd7);
      do_read(32'h30, rd, rsp);
      check("bp_write_landed", rd, 32'h0BADF00D);

      // Reset while rvalid is high
      araddr = 32'h10; arvalid = 1;
      @(posedge clk); #1;
      arvalid = 0;
      check("mr_rvalid_before", {31'd0, rvalid}, 32'd1);
      #2 reset_n = 0;
      #1;
      check("mr_rvalid_async", {31'd0, rvalid}, 32'd0);
      check("mr_rdata_async", rdata, 32'd0);
      check("mr_arready_async", {31'd0, arready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      @(posedge clk); #1;
      check("mr_readies_back", {29'd0, awready, wready, arready}, 32'd7);
      do_read(32'h10, rd, rsp);
      check("mr_ram_cleared", rd, 32'd0);

      // Write commit and AR to the same word on the same edge
      wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
      @(posedge clk); #1;
      wvalid = 0;
      awaddr = 32'h0; awvalid = 1; araddr = 32'h0; arvalid = 1;
      @(posedge clk); #1;
      awvalid = 0; arvalid = 0;
      check("col_bvalid", {31'd0, bvalid}, 32'd1);
      check("col_rvalid", {31'd0, rvalid}, 32'd1);
      check("col_rdata_old", rdata, 32'd0);
      bready = 1; rready = 1;
      @(posedge clk); #1;
      bready = 0; rready = 0;
      do_read(32'h0, rd, rsp);
      check("col_rdata_new", rd, 32'h5);

      // Random traffic against the array model
      for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
      model_mem[0] = 32'h5;
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a, d, word, exp_d;
         logic [3:0]  s;
         bit          err;
         a    = ($urandom_range(0, 511) << 2) | $urandom_range(0, 3);
         word = a >> 2;
         err  = ERR_EN && (word >= 256);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), rsp);
            check("rand_bresp", {30'd0, rsp}, err ? 32'd2 : 32'd0);
            if (!err) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) model_mem[word % 256][b*8 +: 8] = d[b*8 +: 8];
            end
         end else begin
            do_read(a, rd, rsp);
            exp_d = err ? 32'd0 : model_mem[word % 256];
            check("rand_rdata", rd, exp_d);
            check("rand_rresp", {30'd0, rsp}, err ? 32'd2 : 32'd0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
